// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: FSM encoding,
// stall-vector bit positions and common constants.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IF_BUS   = 3'd1,
    ST_MEM_BUS  = 3'd2,
    ST_IF_DONE  = 3'd3,
    ST_MEM_DONE = 3'd4
  } arb_state_e;

  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [3:0]  SEL_WORD  = 4'hF;

  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

  function automatic logic is_bus_state(input arb_state_e s);
    return (s == ST_IF_BUS) || (s == ST_MEM_BUS);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port Wishbone-style bus arbiter between instruction fetch and the MEM stage.
// Optional ack timeout with bus_err_o pulse is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
`ifdef ARB_TIMEOUT_EN
  ,
  output logic        bus_err_o
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  state_reg, state_next;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  sel_reg;
  logic        we_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] mem_rdata_reg;
  logic        if_discard_reg;

  logic        start_mem;
  logic        start_if;
  logic        timeout_hit;
  logic        bus_done;
  logic        discard_now;
  logic        if_capture;
  logic        mem_capture;
  logic [31:0] cap_data;

  // Only the IF/ID and MEM/WB hold bits matter here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  // MEM wins over IF in IDLE; a flushed fetch is never started.
  assign start_mem   = (state_reg == ST_IDLE) && mem_req_i;
  assign start_if    = (state_reg == ST_IDLE) && !mem_req_i && if_req_i && !flush_i;
  assign bus_done    = bus_ack_i || timeout_hit;
  assign discard_now = if_discard_reg || flush_i;
  assign cap_data    = bus_ack_i ? bus_rdata_i : ZeroWord;
  assign if_capture  = (state_reg == ST_IF_BUS) && bus_done;
  // Stores leave the load-data register alone unless the cycle timed out.
  assign mem_capture = (state_reg == ST_MEM_BUS) && (bus_ack_i ? !we_reg : timeout_hit);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_reg;
  logic [CNT_W:0]   to_cnt_inc;
  logic             err_reg;

  assign to_cnt_inc  = {1'b0, to_cnt_reg} + (CNT_W+1)'(1);
  assign timeout_hit = is_bus_state(state_reg) && !bus_ack_i &&
                       (to_cnt_inc == (CNT_W+1)'(TIMEOUT_CYCLES));

  // Counter sits at zero outside the bus states, so it is clear on every BUS entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= timeout_hit;
      if (!is_bus_state(state_reg)) begin
        to_cnt_reg <= '0;
      end else if (!bus_ack_i) begin
        to_cnt_reg <= to_cnt_inc[CNT_W-1:0];
      end
    end
  end

  assign bus_err_o = err_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_mem) begin
          state_next = ST_MEM_BUS;
        end else if (start_if) begin
          state_next = ST_IF_BUS;
        end
      end
      ST_IF_BUS: begin
        if (bus_done) begin
          state_next = discard_now ? ST_IDLE : ST_IF_DONE;
        end
      end
      ST_MEM_BUS: begin
        if (bus_done) begin
          state_next = ST_MEM_DONE;
        end
      end
      ST_IF_DONE: begin
        if ((stall_i[STALL_IF] == NoStop) || flush_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_MEM_DONE: begin
        if (stall_i[STALL_MEM] != Stop) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_cyc_o   = 1'b0;
    bus_stb_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_sel_o   = 4'h0;
    bus_addr_o  = ZeroWord;
    bus_wdata_o = ZeroWord;
    if (is_bus_state(state_reg)) begin
      bus_cyc_o   = 1'b1;
      bus_stb_o   = 1'b1;
      bus_we_o    = we_reg;
      bus_sel_o   = sel_reg;
      bus_addr_o  = addr_reg;
      bus_wdata_o = wdata_reg;
    end
    if_ack_o  = (state_reg == ST_IF_DONE);
    mem_ack_o = (state_reg == ST_MEM_DONE);
    // Gated by rst so the requests also drop while reset is held.
    stallreq_mem_o = rst && mem_req_i && (state_reg != ST_MEM_DONE);
    stallreq_if_o  = rst && if_req_i && (state_reg != ST_IF_DONE) && !flush_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg       <= ZeroWord;
      wdata_reg      <= ZeroWord;
      sel_reg        <= 4'h0;
      we_reg         <= 1'b0;
      if_rdata_reg   <= ZeroWord;
      mem_rdata_reg  <= ZeroWord;
      if_discard_reg <= 1'b0;
    end else begin
      if (start_mem) begin
        addr_reg  <= mem_addr_i;
        wdata_reg <= mem_wdata_i;
        sel_reg   <= mem_sel_i;
        we_reg    <= mem_we_i;
      end else if (start_if) begin
        addr_reg  <= if_addr_i;
        wdata_reg <= ZeroWord;
        sel_reg   <= SEL_WORD;
        we_reg    <= 1'b0;
      end
      if (if_capture) begin
        if_rdata_reg <= cap_data;
      end
      if (mem_capture) begin
        mem_rdata_reg <= cap_data;
      end
      if (state_next == ST_IDLE) begin
        if_discard_reg <= 1'b0;
      end else if ((state_reg == ST_IF_BUS) && flush_i) begin
        if_discard_reg <= 1'b1;
      end
    end
  end

  assign if_rdata_o  = if_rdata_reg;
  assign mem_rdata_o = mem_rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus cycles and acks,
// a negedge monitor pops and compares them. Timeout case runs when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
`ifdef ARB_TIMEOUT_EN
  logic        bus_err_o;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    int          len;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t if_q[$];
  ack_exp_t mem_q[$];

  int compared   = 0;
  int mismatched = 0;

  int          slave_wait;
  logic [31:0] slave_rdata;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_ack_o       (if_ack_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ack_o      (mem_ack_o),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_cyc_o      (bus_cyc_o),
    .bus_stb_o      (bus_stb_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
`ifdef ARB_TIMEOUT_EN
    ,
    .bus_err_o      (bus_err_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // which: 0 cyc high, 1 cyc low, 2 if_ack, 3 mem_ack
  task automatic wait_cond(input int which, input int budget, input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = bus_cyc_o;
        1: hit = !bus_cyc_o;
        2: hit = if_ack_o;
        default: hit = mem_ack_o;
      endcase
    end
    if (!hit) begin
      compared++;
      mismatched++;
      $display("FAIL %s: condition not seen within %0d cycles, required within budget", name, budget);
    end
  endtask

  // Slave: acks in bus cycle slave_wait+1, driven at the negedge so it is stable at the edge.
  initial begin
    int cnt;
    cnt = 0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_cyc_o) begin
        if (cnt == slave_wait) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = slave_rdata;
        end else begin
          bus_ack_i   = 1'b0;
          bus_rdata_i = 32'h0;
        end
        cnt++;
      end else begin
        cnt         = 0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
      end
    end
  end

  // Monitor: pops an expectation whenever a bus cycle or an ack starts.
  initial begin
    bit       pc, pi, pm, ist, mst;
    int       bl, il, ml;
    bus_exp_t cb;
    ack_exp_t ci, cm;
    pc = 0; pi = 0; pm = 0; ist = 1; mst = 1;
    bl = 0; il = 0; ml = 0;
    cb = '{addr: 32'h0, we: 1'b0, sel: 4'h0, wdata: 32'h0, len: -1};
    ci = '{data: 32'h0, len: -1};
    cm = '{data: 32'h0, len: -1};
    forever begin
      @(negedge clk);
      if (bus_cyc_o && !pc) begin
        bl = 0;
        $display("bus txn: addr=%h we=%0b sel=%b wdata=%h", bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o);
        if (bus_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL bus_unexpected: cycle at addr %h, required none", bus_addr_o);
          cb = '{addr: bus_addr_o, we: bus_we_o, sel: bus_sel_o, wdata: bus_wdata_o, len: -1};
        end else begin
          cb = bus_q.pop_front();
          chk("bus_addr", bus_addr_o, cb.addr);
          chk("bus_we", 32'(bus_we_o), 32'(cb.we));
          chk("bus_sel", 32'(bus_sel_o), 32'(cb.sel));
          chk("bus_stb", 32'(bus_stb_o), 32'd1);
          if (cb.we) chk("bus_wdata", bus_wdata_o, cb.wdata);
        end
      end
      if (bus_cyc_o) bl++;
      if (!bus_cyc_o && pc && cb.len >= 0) chk("bus_len", 32'(bl), 32'(cb.len));

      if (if_ack_o && !pi) begin
        il  = 0;
        ist = 1;
        $display("if ack: rdata=%h", if_rdata_o);
        if (if_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL if_ack_unexpected: if_ack_o=1 rdata=%h, required 0", if_rdata_o);
          ci = '{data: if_rdata_o, len: -1};
        end else begin
          ci = if_q.pop_front();
          chk("if_rdata", if_rdata_o, ci.data);
        end
      end
      if (if_ack_o) begin
        il++;
        ist = ist & (if_rdata_o === ci.data);
      end
      if (!if_ack_o && pi && ci.len >= 0) begin
        chk("if_ack_len", 32'(il), 32'(ci.len));
        chk("if_rdata_hold", 32'(ist), 32'd1);
      end

      if (mem_ack_o && !pm) begin
        ml  = 0;
        mst = 1;
        $display("mem ack: rdata=%h", mem_rdata_o);
        if (mem_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL mem_ack_unexpected: mem_ack_o=1 rdata=%h, required 0", mem_rdata_o);
          cm = '{data: mem_rdata_o, len: -1};
        end else begin
          cm = mem_q.pop_front();
          chk("mem_rdata", mem_rdata_o, cm.data);
        end
      end
      if (mem_ack_o) begin
        ml++;
        mst = mst & (mem_rdata_o === cm.data);
      end
      if (!mem_ack_o && pm && cm.len >= 0) begin
        chk("mem_ack_len", 32'(ml), 32'(cm.len));
        chk("mem_rdata_hold", 32'(mst), 32'd1);
      end

      pc = bus_cyc_o;
      pi = if_ack_o;
      pm = mem_ack_o;
    end
  end

  initial begin
    int m, f;
    bit done;
    rst = 1'b0;
    stall_i = 6'b0; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    slave_wait = 0; slave_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rst_bus_stb", 32'(bus_stb_o), 32'd0);
    chk("rst_bus_we", 32'(bus_we_o), 32'd0);
    chk("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    chk("rst_if_ack", 32'(if_ack_o), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_mem_rdata", mem_rdata_o, 32'd0);
    chk("rst_stallreq_if", 32'(stallreq_if_o), 32'd0);
    chk("rst_stallreq_mem", 32'(stallreq_mem_o), 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // 1: zero-wait fetch held by IF/ID stall for 3 DONE cycles
    stall_i = 6'b000010;
    slave_wait = 0; slave_rdata = 32'h2401_0005;
    bus_q.push_back('{addr: 32'h0000_0100, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 1});
    if_q.push_back('{data: 32'h2401_0005, len: 3});
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    wait_cond(0, 10, "t1_cyc");
    chk("t1_stallreq_if_bus", 32'(stallreq_if_o), 32'd1);
    wait_cond(2, 10, "t1_if_ack");
    repeat (2) @(negedge clk);
    stall_i = 6'b0; if_req_i = 1'b0;
    @(negedge clk);
    chk("t1_if_ack_clear", 32'(if_ack_o), 32'd0);
    chk("t1_if_rdata_kept", if_rdata_o, 32'h2401_0005);
    repeat (2) @(negedge clk);

    // 2: simultaneous IF + MEM store; MEM first, IF after one IDLE cycle
    slave_wait = 0; slave_rdata = 32'hA5A5_0200;
    bus_q.push_back('{addr: 32'h8000_0010, we: 1'b1, sel: 4'b0011, wdata: 32'hDEAD_BEEF, len: 1});
    bus_q.push_back('{addr: 32'h0000_0200, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 1});
    mem_q.push_back('{data: 32'h0, len: 1});
    if_q.push_back('{data: 32'hA5A5_0200, len: 1});
    if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h8000_0010; mem_wdata_i = 32'hDEAD_BEEF;
    m = -1; f = -1; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!if_ack_o) chk("t2_stallreq_if_held", 32'(stallreq_if_o), 32'd1);
      if (mem_ack_o && m < 0) m = i;
      if (bus_cyc_o && !bus_we_o && f < 0 && m >= 0) f = i;
      if (mem_ack_o) begin
        mem_req_i = 1'b0; mem_we_i = 1'b0;
      end
      if (if_ack_o) begin
        if_req_i = 1'b0;
        done = 1'b1;
        break;
      end
    end
    chk("t2_if_done_seen", 32'(done), 32'd1);
    chk("t2_if_after_idle_gap", 32'(f - m), 32'd2);
    repeat (2) @(negedge clk);

    // 3: flush in 2nd cycle of a 3-wait-state fetch
    slave_wait = 3; slave_rdata = 32'h1111_2222;
    bus_q.push_back('{addr: 32'h0000_0300, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 4});
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
    wait_cond(0, 10, "t3_cyc");
    @(negedge clk);
    flush_i = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    wait_cond(1, 10, "t3_cyc_end");
    chk("t3_state_idle", 32'(dut.state_reg), 32'(ST_IDLE));
    chk("t3_if_ack_low", 32'(if_ack_o), 32'd0);
    repeat (2) @(negedge clk);

    // 4: load acked with MEM/WB held for 4 cycles
    stall_i = 6'b010000;
    slave_wait = 1; slave_rdata = 32'h1234_5678;
    bus_q.push_back('{addr: 32'h0000_0040, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 2});
    mem_q.push_back('{data: 32'h1234_5678, len: 4});
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
    mem_addr_i = 32'h0000_0040; mem_wdata_i = 32'h0;
    wait_cond(0, 10, "t4_cyc");
    chk("t4_stallreq_mem_bus", 32'(stallreq_mem_o), 32'd1);
    wait_cond(3, 10, "t4_mem_ack");
    chk("t4_stallreq_mem_done", 32'(stallreq_mem_o), 32'd0);
    repeat (3) @(negedge clk);
    stall_i = 6'b0; mem_req_i = 1'b0;
    @(negedge clk);
    chk("t4_state_idle", 32'(dut.state_reg), 32'(ST_IDLE));
    chk("t4_mem_rdata_kept", mem_rdata_o, 32'h1234_5678);
    repeat (2) @(negedge clk);

    // 5: reset asserted in the 2nd cycle of a MEM store
    slave_wait = 1000;
    bus_q.push_back('{addr: 32'h0000_0060, we: 1'b1, sel: 4'b1100, wdata: 32'h55AA_55AA, len: 2});
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1100;
    mem_addr_i = 32'h0000_0060; mem_wdata_i = 32'h55AA_55AA;
    wait_cond(0, 10, "t5_cyc");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_bus_cyc", 32'(bus_cyc_o), 32'd0);
    chk("t5_rst_bus_stb", 32'(bus_stb_o), 32'd0);
    chk("t5_rst_bus_addr", bus_addr_o, 32'd0);
    chk("t5_rst_mem_ack", 32'(mem_ack_o), 32'd0);
    chk("t5_rst_if_ack", 32'(if_ack_o), 32'd0);
    chk("t5_rst_mem_rdata", mem_rdata_o, 32'd0);
    chk("t5_rst_if_rdata", if_rdata_o, 32'd0);
    chk("t5_rst_stallreq_mem", 32'(stallreq_mem_o), 32'd0);
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    slave_wait = 0; slave_rdata = 32'hCAFE_0001;
    bus_q.push_back('{addr: 32'h0000_0080, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 1});
    mem_q.push_back('{data: 32'hCAFE_0001, len: 1});
    mem_req_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0080; mem_wdata_i = 32'h0;
    wait_cond(3, 10, "t5_mem_ack");
    mem_req_i = 1'b0;
    repeat (2) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // 6: slave never acks, TIMEOUT_CYCLES = 4
    slave_wait = 1000;
    bus_q.push_back('{addr: 32'h0000_0044, we: 1'b0, sel: 4'hF, wdata: 32'h0, len: 4});
    mem_q.push_back('{data: 32'h0, len: 1});
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0044;
    wait_cond(0, 10, "t6_cyc");
    wait_cond(1, 20, "t6_cyc_end");
    chk("t6_bus_err_pulse", 32'(bus_err_o), 32'd1);
    chk("t6_mem_ack", 32'(mem_ack_o), 32'd1);
    chk("t6_mem_rdata_zero", mem_rdata_o, 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk);
    chk("t6_bus_err_clear", 32'(bus_err_o), 32'd0);
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
